// File: rtl/axi_lite_ram_slave_if.sv
// AXI-Lite bus bundle between the no-cache memory master and the RAM responder.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi_lite_ram_slave_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI-Lite responder backed by a word-addressed RAM; independent read and write
// machines, one outstanding transaction each, SLVERR outside the mapped window.
module axi_lite_ram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned SIZE_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_lite_ram_slave_if.slave  axi_lite
);
    localparam int unsigned IDX_W       = $clog2(SIZE_WORDS);
    localparam logic [31:0] LIMIT_WORDS = 32'(SIZE_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

    function automatic logic in_range_f(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> 32'd2) < LIMIT_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] index_f(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 32'd2);
    endfunction

    function automatic logic [31:0] merge_f(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]     mem_r [SIZE_WORDS];

    w_state_t        w_state_r;
    logic            aw_held_r;
    logic            w_held_r;
    logic [31:0]     awaddr_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wstrb_r;
    logic            awready_r;
    logic            wready_r;
    logic            bvalid_r;
    logic [1:0]      bresp_r;

    r_state_t        r_state_r;
    logic            arready_r;
    logic            rvalid_r;
    logic [31:0]     rdata_r;
    logic [1:0]      rresp_r;

    logic            aw_hs_s;
    logic            w_hs_s;
    logic            ar_hs_s;
    logic            commit_s;
    logic [31:0]     wr_addr_s;
    logic [31:0]     wr_data_s;
    logic [3:0]      wr_strb_s;
    logic            wr_ok_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic            rd_ok_s;
    logic [IDX_W-1:0] rd_idx_s;

    // Handshake decode and write-commit operand selection (held copy or live bus)
    always_comb begin
        aw_hs_s   = axi_lite.awvalid & awready_r;
        w_hs_s    = axi_lite.wvalid & wready_r;
        ar_hs_s   = axi_lite.arvalid & arready_r;
        if (aw_held_r) begin
            wr_addr_s = awaddr_r;
        end else begin
            wr_addr_s = axi_lite.awaddr;
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = axi_lite.wdata;
            wr_strb_s = axi_lite.wstrb;
        end
        commit_s  = (w_state_r == W_IDLE) && (aw_held_r | aw_hs_s) && (w_held_r | w_hs_s);
        wr_ok_s   = in_range_f(wr_addr_s);
        wr_idx_s  = index_f(wr_addr_s);
        rd_ok_s   = in_range_f(axi_lite.araddr);
        rd_idx_s  = index_f(axi_lite.araddr);
    end

    // RAM array: contents survive reset, byte lanes merged under strobe
    always_ff @(posedge clk) begin
        if (commit_s && wr_ok_s) begin
            mem_r[wr_idx_s] <= merge_f(mem_r[wr_idx_s], wr_data_s, wr_strb_s);
        end
    end

    // Write channel state machine with registered readies and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= 32'h0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (commit_s) begin
                        w_state_r <= W_RESP;
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (aw_hs_s) begin
                            aw_held_r <= 1'b1;
                            awaddr_r  <= axi_lite.awaddr;
                            awready_r <= 1'b0;
                        end
                        if (w_hs_s) begin
                            w_held_r  <= 1'b1;
                            wdata_r   <= axi_lite.wdata;
                            wstrb_r   <= axi_lite.wstrb;
                            wready_r  <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_lite.bready) begin
                        w_state_r <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    aw_held_r <= 1'b0;
                    w_held_r  <= 1'b0;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b1;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel state machine; the RAM sample here sees pre-commit contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_state_r <= R_RESP;
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rdata_r   <= rd_ok_s ? mem_r[rd_idx_s] : 32'h0;
                        rresp_r   <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (axi_lite.rready) begin
                        r_state_r <= R_IDLE;
                        arready_r <= 1'b1;
                        rvalid_r  <= 1'b0;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign axi_lite.awready = awready_r;
    assign axi_lite.wready  = wready_r;
    assign axi_lite.bvalid  = bvalid_r;
    assign axi_lite.bresp   = bresp_r;
    assign axi_lite.arready = arready_r;
    assign axi_lite.rvalid  = rvalid_r;
    assign axi_lite.rdata   = rdata_r;
    assign axi_lite.rresp   = rresp_r;
endmodule
